// File: rtl/spi_fanout_master_pkg.sv
// rtl/spi_fanout_master_pkg.sv - FSM states and command-validity check shared by the SPI fanout master
package spi_fanout_master_pkg;

    localparam int NUM_BITS_WIDTH = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // A command is refused when it asks for no bits, more bits than the data path holds,
    // or a slave port that does not exist.
    function automatic logic cmd_rejected(
        input logic [31:0] num_bits,
        input logic [31:0] slave_sel,
        input logic [31:0] max_bits,
        input logic [31:0] num_slaves
    );
        return (num_bits == 32'd0) || (num_bits > max_bits) || (slave_sel >= num_slaves);
    endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// rtl/spi_edge_gen.sv - half-period counter producing boundary, leading-edge and trailing-edge strobes
module spi_edge_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 run,
    input  logic                 shift_en,
    output logic                 half_end,
    output logic                 lead_edge,
    output logic                 trail_edge
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 phase;

    // Count down each half-period, reload at the boundary, and track which sclk edge comes next
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= '0;
            phase <= 1'b0;
        end else if (load) begin
            cnt   <= divider;
            div_q <= divider;
            phase <= 1'b0;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= div_q;
                if (shift_en) begin
                    phase <= ~phase;
                end
            end else begin
                cnt <= cnt - DIV_WIDTH'(1);
            end
        end
    end

    assign half_end   = run && (cnt == '0);
    assign lead_edge  = half_end && shift_en && !phase;
    assign trail_edge = half_end && shift_en && phase;

endmodule

// File: rtl/spi_fanout_master.sv
// rtl/spi_fanout_master.sv - SPI master with per-command mode, divider and length, fanned out to NUM_SLAVES ports
module spi_fanout_master
    import spi_fanout_master_pkg::*;
#(
    parameter int NUM_SLAVES = 9,
    parameter int SEL_WIDTH  = 4,
    parameter int MAX_BITS   = 32,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      ready,
    input  logic [SEL_WIDTH-1:0]      slave_sel,
    input  logic [NUM_BITS_WIDTH-1:0] num_bits,
    input  logic [DIV_WIDTH-1:0]      divider,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic [MAX_BITS-1:0]       tx_data,
    output logic [MAX_BITS-1:0]       rx_data,
    output logic                      done,
    output logic                      err,
    output logic [NUM_SLAVES-1:0]     sen,
    output logic [NUM_SLAVES-1:0]     sclk,
    output logic [NUM_SLAVES-1:0]     mosi,
    input  logic [NUM_SLAVES-1:0]     miso
);

    state_t                    state;
    logic [SEL_WIDTH-1:0]      sel_q;
    logic                      cpha_q;
    logic [NUM_BITS_WIDTH:0]   hp_left;
    logic [MAX_BITS-1:0]       tx_sr;
    logic [MAX_BITS-1:0]       rx_sr;
    logic [MAX_BITS-1:0]       tx_aligned;
    logic                      act_en;
    logic                      act_sclk;
    logic                      act_mosi;
    logic [NUM_SLAVES-1:0]     sel_oh;
    logic                      miso_sel;
    logic                      accept;
    logic                      bad_cmd;
    logic                      run;
    logic                      shift_en;
    logic                      half_end;
    logic                      lead_edge;
    logic                      trail_edge;
    logic                      sample_edge;
    logic                      shift_edge;

    assign accept  = start && ready;
    assign bad_cmd = cmd_rejected(32'(num_bits), 32'(slave_sel), 32'(MAX_BITS), 32'(NUM_SLAVES));

    // Left-align the word so the MSB of the requested length always leaves from the top bit
    assign tx_aligned = tx_data << (7'(MAX_BITS) - {1'b0, num_bits});

    assign run         = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign shift_en    = (state == ST_SHIFT);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    spi_edge_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_edge_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (accept && !bad_cmd),
        .divider    (divider),
        .run        (run),
        .shift_en   (shift_en),
        .half_end   (half_end),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    // Decode the latched slave index and gate the single active lane onto that port only
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_oh[i] = (sel_q == SEL_WIDTH'(i));
        end
        sen      = ~(sel_oh & {NUM_SLAVES{act_en}});
        sclk     = sel_oh & {NUM_SLAVES{act_en & act_sclk}};
        mosi     = sel_oh & {NUM_SLAVES{act_en & act_mosi}};
        miso_sel = |(miso & sel_oh);
    end

    // Transaction sequencer: latch command, run setup/shift/hold half-periods, publish result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            rx_data  <= '0;
            sel_q    <= '0;
            cpha_q   <= 1'b0;
            hp_left  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            act_en   <= 1'b0;
            act_sclk <= 1'b0;
            act_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    if (accept) begin
                        if (bad_cmd) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= ST_SETUP;
                            ready    <= 1'b0;
                            sel_q    <= slave_sel;
                            cpha_q   <= cpha;
                            hp_left  <= {num_bits, 1'b0};
                            rx_sr    <= '0;
                            act_en   <= 1'b1;
                            act_sclk <= cpol;
                            // cpha=0 presents the MSB before the first edge; cpha=1 waits for it
                            if (cpha) begin
                                tx_sr    <= tx_aligned;
                                act_mosi <= 1'b0;
                            end else begin
                                tx_sr    <= tx_aligned << 1;
                                act_mosi <= tx_aligned[MAX_BITS-1];
                            end
                        end
                    end
                end
                ST_SETUP: begin
                    if (half_end) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (half_end) begin
                        act_sclk <= ~act_sclk;
                        hp_left  <= hp_left - 7'd1;
                        if (hp_left == 7'd1) begin
                            state <= ST_HOLD;
                        end
                        if (sample_edge) begin
                            rx_sr <= {rx_sr[MAX_BITS-2:0], miso_sel};
                        end
                        if (shift_edge) begin
                            act_mosi <= tx_sr[MAX_BITS-1];
                            tx_sr    <= tx_sr << 1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (half_end) begin
                        state    <= ST_DONE;
                        ready    <= 1'b1;
                        done     <= 1'b1;
                        rx_data  <= rx_sr;
                        act_en   <= 1'b0;
                        act_sclk <= 1'b0;
                        act_mosi <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fanout_master.sv
// tb/tb_spi_fanout_master.sv - self-checking bench with a behavioural SPI slave model
module tb_spi_fanout_master;

    localparam int NS = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ready;
    logic [3:0]    slave_sel = '0;
    logic [5:0]    num_bits = '0;
    logic [15:0]   divider = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic [31:0]   tx_data = '0;
    logic [31:0]   rx_data;
    logic          done;
    logic          err;
    logic [NS-1:0] sen;
    logic [NS-1:0] sclk;
    logic [NS-1:0] mosi;
    logic [NS-1:0] miso = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_sel = 0;
    int          m_n = 1;
    logic        m_cpol = 1'b0;
    logic        m_cpha = 1'b0;
    logic [31:0] m_word = '0;

    int          xfer_cnt = 0;
    int          lead_cnt = 0;
    int          quiet_err = 0;
    int          idle_bad = 0;
    int          stable_bad = 0;
    int          out_idx = 0;
    logic [31:0] slave_rx = '0;
    logic        mbit = 1'b0;
    logic        p_sen = 1'b1;
    logic        p_sclk = 1'b0;
    logic        p_mosi = 1'b0;

    always #5 clk = ~clk;

    spi_fanout_master dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .slave_sel (slave_sel),
        .num_bits  (num_bits),
        .divider   (divider),
        .cpol      (cpol),
        .cpha      (cpha),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .done      (done),
        .err       (err),
        .sen       (sen),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso)
    );

    // SPI slave: leading edge leaves the idle level; cpha chooses which edge samples and which shifts
    always @(negedge clk) begin : slave_model
        logic s_sen;
        logic s_sclk;
        logic s_mosi;
        logic lead;
        for (int i = 0; i < NS; i++) begin
            if (i != m_sel && (sen[i] !== 1'b1 || sclk[i] !== 1'b0 || mosi[i] !== 1'b0)) quiet_err++;
        end
        s_sen  = sen[m_sel];
        s_sclk = sclk[m_sel];
        s_mosi = mosi[m_sel];
        if (s_sen === 1'b1 && (s_sclk !== 1'b0 || s_mosi !== 1'b0)) quiet_err++;
        if (p_sen && !s_sen) begin
            xfer_cnt++;
            lead_cnt = 0;
            slave_rx = '0;
            if (s_sclk !== m_cpol) idle_bad++;
            if (m_cpha) begin
                out_idx = m_n - 1;
                mbit    = 1'b0;
            end else begin
                mbit    = m_word[m_n-1];
                out_idx = m_n - 2;
            end
        end else if (!s_sen && !p_sen && s_sclk !== p_sclk) begin
            lead = (p_sclk == m_cpol);
            if (lead) lead_cnt++;
            if (lead ^ m_cpha) begin
                slave_rx = {slave_rx[30:0], s_mosi};
                if (s_mosi !== p_mosi) stable_bad++;
            end else begin
                mbit = (out_idx >= 0) ? m_word[out_idx] : 1'b0;
                out_idx--;
            end
        end
        miso        = NS'($urandom);
        miso[m_sel] = mbit;
        p_sen  = s_sen;
        p_sclk = s_sclk;
        p_mosi = s_mosi;
    end

    function automatic logic [31:0] low_bits(input logic [31:0] w, input int n);
        return (n >= 32) ? w : (w & ((32'd1 << n) - 32'd1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input string tag, input int sel, input int n, input int d,
                            input logic cp, input logic ch,
                            input logic [31:0] tx, input logic [31:0] word);
        int          lat;
        int          xb;
        logic        rej;
        logic [31:0] rx_before;
        rej       = (n == 0) || (n > 32) || (sel >= NS);
        @(negedge clk);
        xb        = xfer_cnt;
        rx_before = rx_data;
        m_sel  = (sel < NS) ? sel : 0;
        m_n    = (n >= 1 && n <= 32) ? n : 1;
        m_cpol = cp;
        m_cpha = ch;
        m_word = word;
        slave_sel = 4'(sel);
        num_bits  = 6'(n);
        divider   = 16'(d);
        cpol      = cp;
        cpha      = ch;
        tx_data   = tx;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        slave_sel = 4'($urandom);
        num_bits  = 6'($urandom);
        divider   = 16'($urandom);
        cpol      = 1'($urandom);
        cpha      = 1'($urandom);
        tx_data   = $urandom;
        check({tag, ":ready_c1"}, 32'(ready), rej ? 32'd1 : 32'd0);
        lat = 0;
        for (int k = 1; k <= 20000 && lat == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (done === 1'b1) lat = k;
        end
        check({tag, ":latency"}, lat, rej ? 1 : 1 + (2 * n + 2) * (d + 1));
        check({tag, ":err"}, 32'(err), rej ? 32'd1 : 32'd0);
        check({tag, ":sen_done"}, 32'(sen), 32'h1FF);
        check({tag, ":ready_done"}, 32'(ready), 32'd1);
        check({tag, ":rx_data"}, rx_data, rej ? rx_before : low_bits(word, n));
        check({tag, ":xfers"}, xfer_cnt - xb, rej ? 0 : 1);
        if (!rej) begin
            check({tag, ":slave_rx"}, slave_rx, low_bits(tx, n));
            check({tag, ":lead_edges"}, lead_cnt, n);
        end
    endtask

    initial begin : stimulus
        int nd;
        int xb;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:ready", 32'(ready), 32'd1);
        check("rst:done", 32'(done), 32'd0);
        check("rst:err", 32'(err), 32'd0);
        check("rst:rx_data", rx_data, 32'd0);
        check("rst:sen", 32'(sen), 32'h1FF);
        check("rst:sclk", 32'(sclk), 32'd0);
        check("rst:mosi", 32'(mosi), 32'd0);
        rst = 1'b0;

        run_xfer("t1", 2, 8, 0, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_003C);

        for (int m = 0; m < 4; m++) begin
            run_xfer("t2_mode", m, 16, 3, 1'(m >> 1), 1'(m), 32'h0000_1234, 32'h0000_1234);
        end

        run_xfer("t3", 7, 32, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        run_xfer("t4_sel9", 9, 8, 0, 1'b0, 1'b0, 32'h0000_0055, 32'h0000_00AA);
        run_xfer("t4_n0", 3, 0, 0, 1'b0, 1'b0, 32'h0000_0055, 32'h0000_00AA);
        run_xfer("t4_n33", 3, 33, 0, 1'b1, 1'b1, 32'h0000_0055, 32'h0000_00AA);

        @(negedge clk);
        m_sel = 2; m_n = 8; m_cpol = 1'b0; m_cpha = 1'b0; m_word = 32'h3C;
        slave_sel = 4'd2; num_bits = 6'd8; divider = 16'd0; cpol = 1'b0; cpha = 1'b0;
        tx_data = 32'hA5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("t5:sen_busy_c10", 32'(sen[2]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5:sen_c11", 32'(sen), 32'h1FF);
        check("t5:ready_c11", 32'(ready), 32'd1);
        check("t5:done_c11", 32'(done), 32'd0);
        check("t5:sclk_c11", 32'(sclk), 32'd0);
        check("t5:mosi_c11", 32'(mosi), 32'd0);
        rst = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("t5:no_done", nd, 0);

        @(negedge clk);
        xb = xfer_cnt;
        m_sel = 5; m_n = 4; m_cpol = 1'b1; m_cpha = 1'b0; m_word = 32'h9;
        slave_sel = 4'd5; num_bits = 6'd4; divider = 16'd1; cpol = 1'b1; cpha = 1'b0;
        tx_data = 32'h6; start = 1'b1;
        nd = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (nd == 1 && start) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) check("t6:sen_gap", 32'(sen), 32'h1FF);
            end
        end
        check("t6:done_count", nd, 2);
        check("t6:xfers", xfer_cnt - xb, 2);
        check("t6:rx_data", rx_data, 32'h9);
        check("t6:slave_rx", slave_rx, 32'h6);

        for (int r = 0; r < 12; r++) begin
            run_xfer("rand", $urandom_range(0, NS - 1), $urandom_range(1, 32), $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), $urandom, $urandom);
        end

        check("quiet_ports", quiet_err, 0);
        check("sclk_idle_level", idle_bad, 0);
        check("mosi_stable_at_sample", stable_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
